multi_delay_timer: RTL

- Parametrised, multi-channel successor to the single fixed-period delay counter.
- NCH independent channels, each with a runtime-programmable period, periodic or one-shot mode, and per-channel enable.
- Each expiry is held as a pending event until acknowledged; a missed acknowledge is recorded as a sticky overrun.
- Sits beside the system tick logic as a shared timebase; the bench checks both safety and liveness properties.

---
 rtl/multi_delay_timer_pkg.sv | 24 ++
 rtl/multi_delay_timer_chan.sv | 121 ++++++++++++
 rtl/multi_delay_timer.sv | 65 ++++++
 3 files changed

// File: rtl/multi_delay_timer_pkg.sv
// multi_delay_timer_pkg
//   Shared types for the multi-channel delay timer:
//     chan_state_e : per-channel state machine encoding (IDLE/RUN/DONE)
//     chan_mode_e  : expiry behaviour (periodic reload or one-shot)
//     ch_w()       : width of the channel-select field for a given NCH
package multi_delay_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chan_state_e;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } chan_mode_e;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_delay_timer_chan.sv
// delay_chan
//   One timer channel: state machine, counter, period/mode registers and
//   the sticky pend/ovf event flags.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     en           : level-sensitive channel enable
//     cfg_wr       : one-cycle write strobe already decoded for this channel
//     cfg_period   : period loaded on cfg_wr
//     cfg_oneshot  : mode loaded on cfg_wr (1 = one-shot)
//     ack          : clears pend
//     sig          : expiry pulse (RUN and cnt == period)
//     flg          : RUN and cnt < period
//     pend, ovf    : sticky expiry-pending and overrun flags
module delay_chan
    import multi_delay_timer_pkg::*;
#(
    parameter int unsigned CBITS     = 11,
    parameter int unsigned DEFAULT_N = 1250
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_wr,
    input  logic [CBITS-1:0] cfg_period,
    input  logic             cfg_oneshot,
    input  logic             ack,
    output logic             sig,
    output logic             flg,
    output logic             pend,
    output logic             ovf
);

    localparam logic [CBITS-1:0] DEF_PERIOD = CBITS'(DEFAULT_N);

    chan_state_e      state;
    chan_mode_e       mode;
    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] period;
    logic             expire;
    logic             live_run;

    assign expire = (state == RUN) && (cnt == period);
    assign sig    = expire;
    assign flg    = (state == RUN) && (cnt < period);

    // Conditions under which the channel must keep producing pulses.
    assign live_run = (state == RUN) && en && !cfg_wr && (mode == MODE_PERIODIC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode   <= MODE_PERIODIC;
            cnt    <= '0;
            period <= DEF_PERIOD;
            pend   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            // An ack coinciding with an expiry consumes the old event while
            // the new one keeps pend set, so it is not an overrun.
            if (expire)
                pend <= 1'b1;
            else if (ack)
                pend <= 1'b0;

            if (cfg_wr)
                ovf <= 1'b0;
            else if (expire && pend && !ack)
                ovf <= 1'b1;

            // A cfg write overrides the normal next-state, but sig for the
            // current cycle is combinational and already out.
            if (cfg_wr) begin
                period <= cfg_period;
                mode   <= cfg_oneshot ? MODE_ONESHOT : MODE_PERIODIC;
                cnt    <= '0;
                state  <= en ? RUN : IDLE;
            end else if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                    RUN: begin
                        if (cnt == period) begin
                            cnt <= '0;
                            if (mode == MODE_ONESHOT)
                                state <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        cnt <= '0;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Safety: the counter is bounded by the period.
    a_cnt_bounded: assert property (@(posedge clk) disable iff (rst)
        cnt <= period);

    // Liveness in bounded form: while undisturbed the counter advances each
    // cycle until expiry, and flg stays up from the cycle after an expiry
    // until the next sig. With cnt <= period this forces sig within
    // period+1 cycles.
    a_progress: assert property (@(posedge clk) disable iff (rst)
        (live_run && !expire) |=> (cnt == $past(cnt) + 1'b1));

    a_flg_until_sig: assert property (@(posedge clk) disable iff (rst)
        (live_run && (expire || flg)) |=> (flg || sig));

endmodule

// File: rtl/multi_delay_timer.sv
// multi_delay_timer
//   NCH independent programmable delay timers sharing one clock.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     en[NCH]      : per-channel enable
//     cfg_we       : configuration write strobe
//     cfg_ch       : target channel (out-of-range writes are dropped)
//     cfg_period   : new period, cfg_oneshot : new mode (1 = one-shot)
//     ack[NCH]     : per-channel pending acknowledge
//     sig[NCH]     : expiry pulse, flg[NCH] : counting below period
//     pend[NCH]    : sticky pending event, ovf[NCH] : sticky overrun
module multi_delay_timer
    import multi_delay_timer_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned CBITS     = 11,
    parameter int unsigned DEFAULT_N = 1250
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         en,
    input  logic                   cfg_we,
    input  logic [ch_w(NCH)-1:0]   cfg_ch,
    input  logic [CBITS-1:0]       cfg_period,
    input  logic                   cfg_oneshot,
    input  logic [NCH-1:0]         ack,
    output logic [NCH-1:0]         sig,
    output logic [NCH-1:0]         flg,
    output logic [NCH-1:0]         pend,
    output logic [NCH-1:0]         ovf
);

    localparam int unsigned CH_W = ch_w(NCH);

    logic [NCH-1:0] cfg_wr;

    // Indices >= NCH match no channel, so such writes fall away.
    always_comb begin
        cfg_wr = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (cfg_we && (cfg_ch == CH_W'(i)))
                cfg_wr[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        delay_chan #(
            .CBITS     (CBITS),
            .DEFAULT_N (DEFAULT_N)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .en          (en[g]),
            .cfg_wr      (cfg_wr[g]),
            .cfg_period  (cfg_period),
            .cfg_oneshot (cfg_oneshot),
            .ack         (ack[g]),
            .sig         (sig[g]),
            .flg         (flg[g]),
            .pend        (pend[g]),
            .ovf         (ovf[g])
        );
    end

endmodule
